// File: rtl/yuv_pkg.sv
// yuv_pkg: BT.601 integer coefficients, offsets, saturation helper and UYVY serializer state encoding.
package yuv_pkg;
    typedef logic signed [18:0] s19_t;
    localparam s19_t KY_R = 19'sd66;
    localparam s19_t KY_G = 19'sd129;
    localparam s19_t KY_B = 19'sd25;
    localparam s19_t KU_R = -19'sd38;
    localparam s19_t KU_G = -19'sd74;
    localparam s19_t KU_B = 19'sd112;
    localparam s19_t KV_R = 19'sd112;
    localparam s19_t KV_G = -19'sd94;
    localparam s19_t KV_B = -19'sd18;
    localparam s19_t Y_OFF = 19'sd16;
    localparam s19_t C_OFF = 19'sd128;
    localparam s19_t RND = 19'sd128;
    localparam int BYTES_PER_PAIR = 4;
    typedef enum logic [1:0] {S_U, S_Y0, S_V, S_Y1} ser_state_t;
    function automatic logic [7:0] sat8(input s19_t x);
        return (x < 0) ? 8'd0 : (x > 19'sd255) ? 8'd255 : x[7:0];
    endfunction
endpackage

// File: rtl/rgb_to_ycbcr_px.sv
// rgb_to_ycbcr_px: combinational BT.601 conversion of one pixel's luma plus one chroma channel (U, or V when IS_V)
// taken from a separate chroma source pixel; results saturated to 0..255.
module rgb_to_ycbcr_px
    import yuv_pkg::*;
#(
    parameter bit IS_V = 1'b0
) (
    input  logic [7:0] r,
    input  logic [7:0] g,
    input  logic [7:0] b,
    input  logic [7:0] cr,
    input  logic [7:0] cg,
    input  logic [7:0] cb,
    output logic [7:0] y,
    output logic [7:0] c
);
    s19_t r_s, g_s, b_s, cr_s, cg_s, cb_s;
    assign r_s = {11'd0, r};
    assign g_s = {11'd0, g};
    assign b_s = {11'd0, b};
    assign cr_s = {11'd0, cr};
    assign cg_s = {11'd0, cg};
    assign cb_s = {11'd0, cb};
    assign y = sat8(((KY_R * r_s + KY_G * g_s + KY_B * b_s + RND) >>> 8) + Y_OFF);
    // Arithmetic shift of the signed sum gives floor division for negative chroma.
    assign c = sat8((((IS_V ? KV_R : KU_R) * cr_s + (IS_V ? KV_G : KU_G) * cg_s
                    + (IS_V ? KV_B : KU_B) * cb_s + RND) >>> 8) + C_OFF);
endmodule

// File: rtl/rgb_to_yuv422_packer.sv
// rgb_to_yuv422_packer: RGB pixel pairs -> UYVY byte stream with frame-buffer byte addresses.
// Define CHROMA_AVG_EN to derive U/V from the rounded average of both pixels instead of pixel 0.
module rgb_to_yuv422_packer
    import yuv_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 480,
    parameter int AW     = 20
) (
    input  logic          clk24,
    input  logic          rst,
    input  logic [47:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          frame_end
);
    localparam logic [AW-1:0] LAST = AW'(WIDTH * HEIGHT - 1);
    ser_state_t state, state_next;
    logic [7:0] y0, y1, u, v, cr, cg, cb;
    logic [31:0] a_pair, h_pair;
    logic a_valid, hold_valid, a_move, in_acc, out_acc;
    logic [AW-1:0] addr;
    assign in_acc = in_valid & in_ready;
    assign out_acc = hold_valid & out_ready;
    assign a_move = ~hold_valid | ((state == S_Y1) & out_ready);
    assign in_ready = ~rst & (~a_valid | a_move);
    assign out_valid = hold_valid;
    assign out_addr = addr;
`ifdef CHROMA_AVG_EN
    assign cr = 8'((in_data[23:16] + in_data[47:40] + 9'd1) >> 1);
    assign cg = 8'((in_data[7:0] + in_data[31:24] + 9'd1) >> 1);
    assign cb = 8'((in_data[15:8] + in_data[39:32] + 9'd1) >> 1);
`else
    assign cr = in_data[23:16];
    assign cg = in_data[7:0];
    assign cb = in_data[15:8];
`endif
    rgb_to_ycbcr_px #(.IS_V(1'b0)) u_px0 (
        .r(in_data[23:16]), .g(in_data[7:0]), .b(in_data[15:8]),
        .cr(cr), .cg(cg), .cb(cb), .y(y0), .c(u)
    );
    rgb_to_ycbcr_px #(.IS_V(1'b1)) u_px1 (
        .r(in_data[47:40]), .g(in_data[31:24]), .b(in_data[39:32]),
        .cr(cr), .cg(cg), .cb(cb), .y(y1), .c(v)
    );
    // Stage A feeds the hold register on the same edge the last byte of the held pair leaves.
    always_ff @(posedge clk24) begin
        if (rst) begin
            a_valid <= 1'b0;
            hold_valid <= 1'b0;
            a_pair <= '0;
            h_pair <= '0;
        end else begin
            a_valid <= in_acc | (a_valid & ~a_move);
            if (in_acc) a_pair <= {u, y0, v, y1};
            if (a_move) begin
                hold_valid <= a_valid;
                h_pair <= a_pair;
            end
        end
    end
    always_ff @(posedge clk24) begin
        if (rst) state <= S_U;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        if (out_acc) state_next = (state == ser_state_t'(BYTES_PER_PAIR - 1)) ? S_U : ser_state_t'(state + 2'd1);
    end
    always_comb begin
        out_data = (state == S_U) ? h_pair[31:24] : (state == S_Y0) ? h_pair[23:16]
                 : (state == S_V) ? h_pair[15:8] : h_pair[7:0];
    end
    always_ff @(posedge clk24) begin
        if (rst) begin
            addr <= '0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= out_acc & (addr == LAST);
            if (out_acc) addr <= (addr == LAST) ? '0 : addr + 1'b1;
        end
    end
endmodule
